rr_mux_reg: RTL and testbench

RR_MUX_REG -- requirements
Module: rr_mux_reg

---
 rtl/rr_mux_reg.sv | 120 ++++++++++++
 tb/tb_rr_mux_reg.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_reg.sv
// rr_mux_reg: N-channel arbitrated multiplexer with a single registered output
// stage. Arbitration is either fixed priority (lowest index wins) or
// round-robin, starting the search at a rotating pointer. The output register
// reloads whenever it is empty or being consumed, so a word can be accepted
// and another one consumed in the same cycle without a bubble.
module rr_mux_reg #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int MODE  = 1,
  localparam int CW   = $clog2(N)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [N*WIDTH-1:0]   IN_DATA,
  input  logic [N-1:0]         IN_VALID,
  output logic [N-1:0]         IN_READY,
  output logic [WIDTH-1:0]     OUT_DATA,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [CW-1:0]        OUT_CH
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [CW-1:0]    out_ch_q, out_ch_d;
  logic [CW-1:0]    ptr_q, ptr_d;

  logic [N-1:0]     grant;
  logic [CW-1:0]    sel_ch;
  logic             found;
  logic [CW-1:0]    idx;
  logic [CW:0]      sum;
  logic [WIDTH-1:0] sel_data;
  logic             ld;

  // The output register may take a new word when it is empty or being drained.
  assign ld = ~out_valid_q | OUT_READY;

  // Arbiter: scan channels starting at the pointer (or at 0 for fixed
  // priority) and grant the first one offering a word.
  always_comb begin
    grant  = '0;
    sel_ch = '0;
    found  = 1'b0;
    idx    = '0;
    sum    = '0;
    for (int k = 0; k < N; k++) begin
      if (MODE == 0) begin
        idx = CW'(k);
      end else begin
        sum = {1'b0, ptr_q} + (CW+1)'(k);
        if (sum >= (CW+1)'(N)) begin
          sum = sum - (CW+1)'(N);
        end
        idx = sum[CW-1:0];
      end
      if (!found && IN_VALID[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        sel_ch      = idx;
      end
    end
  end

  // Data select driven by the one-hot grant, so only one slice ever passes.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        sel_data = IN_DATA[i*WIDTH +: WIDTH];
      end
    end
  end

  // Next state of the output stage and the round-robin pointer.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (ld) begin
      out_valid_d = found;
      if (found) begin
        out_data_d = sel_data;
        out_ch_d   = sel_ch;
        if (MODE != 0) begin
          if (sel_ch == CW'(N-1)) begin
            ptr_d = '0;
          end else begin
            ptr_d = sel_ch + CW'(1);
          end
        end
      end
    end
    if (MODE == 0) begin
      ptr_d = '0;
    end
  end

  // State registers; reset clears the held word and the pointer immediately.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign IN_READY  = grant & {N{ld & ~RST}};
  assign OUT_DATA  = out_data_q;
  assign OUT_VALID = out_valid_q;
  assign OUT_CH    = out_ch_q;

endmodule

// File: tb/tb_rr_mux_reg.sv
// Testbench for rr_mux_reg: a round-robin and a fixed-priority instance share
// the same stimulus and are compared against a transaction-level model.
module tb_rr_mux_reg;

  localparam int W = 8;
  localparam int NCH = 4;

  logic           clk;
  logic           rst;
  logic [31:0]    inData;
  logic [3:0]     inValid;
  logic           outReady;

  logic [3:0]     inReadyRr, inReadyFp;
  logic [7:0]     outDataRr, outDataFp;
  logic           outValidRr, outValidFp;
  logic [1:0]     outChRr, outChFp;

  int errors = 0;
  int checks = 0;

  // Model state: what the output register should hold for each instance.
  int   mValid[2];
  int   mData[2];
  int   mCh[2];
  int   mPtr[2];

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic        ready;
    logic [3:0]  expReadyRr;
    logic [1:0]  expChRr;
    logic [7:0]  expDataRr;
    logic [3:0]  expReadyFp;
    logic [1:0]  expChFp;
  } vec_t;

  vec_t vecs[5];

  rr_mux_reg #(.WIDTH(W), .N(NCH), .MODE(1)) dutRr (
    .CLK(clk), .RST(rst), .IN_DATA(inData), .IN_VALID(inValid),
    .IN_READY(inReadyRr), .OUT_DATA(outDataRr), .OUT_VALID(outValidRr),
    .OUT_READY(outReady), .OUT_CH(outChRr)
  );

  rr_mux_reg #(.WIDTH(W), .N(NCH), .MODE(0)) dutFp (
    .CLK(clk), .RST(rst), .IN_DATA(inData), .IN_VALID(inValid),
    .IN_READY(inReadyFp), .OUT_DATA(outDataFp), .OUT_VALID(outValidFp),
    .OUT_READY(outReady), .OUT_CH(outChFp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison with failure report.
  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Channel chosen by the arbitration rule, or -1 when nobody offers a word.
  function automatic int grantOf(input logic [3:0] v, input int startAt);
    for (int k = 0; k < NCH; k++) begin
      int c;
      c = (startAt + k) % NCH;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [3:0] expectedReady(input int m);
    int g;
    g = grantOf(inValid, mPtr[m]);
    if ((mValid[m] == 0 || outReady) && g >= 0) return 4'(1 << g);
    return 4'b0000;
  endfunction

  task automatic modelReset();
    for (int m = 0; m < 2; m++) begin
      mValid[m] = 0; mData[m] = 0; mCh[m] = 0; mPtr[m] = 0;
    end
  endtask

  // Advance the model by one rising edge; instance 0 round-robin, 1 fixed.
  task automatic modelStep();
    for (int m = 0; m < 2; m++) begin
      int g;
      if (mValid[m] == 0 || outReady) begin
        g = grantOf(inValid, mPtr[m]);
        if (g >= 0) begin
          mValid[m] = 1;
          mData[m]  = int'(inData[g*8 +: 8]);
          mCh[m]    = g;
          if (m == 0) mPtr[m] = (g + 1) % NCH;
        end else begin
          mValid[m] = 0;
        end
      end
    end
  endtask

  task automatic checkOutput();
    checkVal("rr_valid", 64'(outValidRr), 64'(mValid[0]));
    checkVal("rr_data",  64'(outDataRr),  64'(mData[0]));
    checkVal("rr_ch",    64'(outChRr),    64'(mCh[0]));
    checkVal("fp_valid", 64'(outValidFp), 64'(mValid[1]));
    checkVal("fp_data",  64'(outDataFp),  64'(mData[1]));
    checkVal("fp_ch",    64'(outChFp),    64'(mCh[1]));
  endtask

  // One cycle: drive at the falling edge, check ready, clock, check outputs.
  task automatic applyStimulus(input logic [3:0] v, input logic [31:0] d, input logic r,
                               output logic [3:0] seenRr, output logic [3:0] seenFp);
    inValid  = v;
    inData   = d;
    outReady = r;
    #1;
    seenRr = inReadyRr;
    seenFp = inReadyFp;
    checkVal("rr_in_ready", 64'(inReadyRr), 64'(expectedReady(0)));
    checkVal("fp_in_ready", 64'(inReadyFp), 64'(expectedReady(1)));
    @(posedge clk);
    modelStep();
    #1;
    checkOutput();
    @(negedge clk);
  endtask

  logic [3:0] sRr, sFp;

  initial begin
    vecs[0] = '{4'b1111, 32'h44332211, 1'b1, 4'b0001, 2'd0, 8'h11, 4'b0001, 2'd0};
    vecs[1] = '{4'b1111, 32'h44332211, 1'b1, 4'b0010, 2'd1, 8'h22, 4'b0001, 2'd0};
    vecs[2] = '{4'b1111, 32'h44332211, 1'b1, 4'b0100, 2'd2, 8'h33, 4'b0001, 2'd0};
    vecs[3] = '{4'b1111, 32'h44332211, 1'b1, 4'b1000, 2'd3, 8'h44, 4'b0001, 2'd0};
    vecs[4] = '{4'b1111, 32'h44332211, 1'b1, 4'b0001, 2'd0, 8'h11, 4'b0001, 2'd0};

    inValid = 4'b1111; inData = 32'hDEADBEEF; outReady = 1'b1;
    rst = 1'b1;
    modelReset();
    #3;
    checkVal("reset_valid", 64'(outValidRr), 64'd0);
    checkVal("reset_data",  64'(outDataRr),  64'd0);
    checkVal("reset_ch",    64'(outChRr),    64'd0);
    checkVal("reset_ready", 64'({inReadyRr, inReadyFp}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Full-throughput rotation and fixed-priority comparison.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].data, vecs[i].ready, sRr, sFp);
      checkVal($sformatf("tbl%0d_rr_ready", i), 64'(sRr), 64'(vecs[i].expReadyRr));
      checkVal($sformatf("tbl%0d_rr_ch", i),    64'(outChRr), 64'(vecs[i].expChRr));
      checkVal($sformatf("tbl%0d_rr_data", i),  64'(outDataRr), 64'(vecs[i].expDataRr));
      checkVal($sformatf("tbl%0d_rr_valid", i), 64'(outValidRr), 64'd1);
      checkVal($sformatf("tbl%0d_fp_ready", i), 64'(sFp), 64'(vecs[i].expReadyFp));
      checkVal($sformatf("tbl%0d_fp_ch", i),    64'(outChFp), 64'(vecs[i].expChFp));
    end

    // Pointer wrap: take channel 2 (pointer to 3), then 0101 grants 0 then 2.
    applyStimulus(4'b0100, 32'h00AA0000, 1'b1, sRr, sFp);
    applyStimulus(4'b0101, 32'h00BB00CC, 1'b1, sRr, sFp);
    checkVal("wrap_grant0", 64'(sRr), 64'b0001);
    applyStimulus(4'b0101, 32'h00BB00CC, 1'b1, sRr, sFp);
    checkVal("wrap_grant2", 64'(sRr), 64'b0100);
    checkVal("wrap_data",   64'(outDataRr), 64'hBB);

    // Backpressure: A5 from channel 2 held for five stalled cycles.
    applyStimulus(4'b0100, 32'h00A50000, 1'b1, sRr, sFp);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b1111, 32'h44332211, 1'b0, sRr, sFp);
      checkVal("bp_ready", 64'(sRr), 64'd0);
      checkVal("bp_data",  64'(outDataRr), 64'hA5);
      checkVal("bp_ch",    64'(outChRr), 64'd2);
    end
    applyStimulus(4'b1111, 32'h44332211, 1'b1, sRr, sFp);
    checkVal("bp_release_ready", 64'(sRr), 64'b1000);
    checkVal("bp_release_data",  64'(outDataRr), 64'h44);

    // Asynchronous reset between edges while a word is held.
    inValid = 4'b0000; outReady = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkVal("async_rst_valid", 64'(outValidRr), 64'd0);
    checkVal("async_rst_data",  64'(outDataRr),  64'd0);
    checkVal("async_rst_ch",    64'(outChRr),    64'd0);
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(4'b1000, 32'h7E000000, 1'b1, sRr, sFp);
    checkVal("post_rst_ch",   64'(outChRr),   64'd3);
    checkVal("post_rst_data", 64'(outDataRr), 64'h7E);

    // Idle input with ready downstream drains the word and keeps data.
    applyStimulus(4'b0000, 32'h12345678, 1'b1, sRr, sFp);
    checkVal("drain_valid", 64'(outValidRr), 64'd0);
    checkVal("drain_data",  64'(outDataRr),  64'h7E);

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 3) != 0), sRr, sFp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
